// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundles the register file's read, writeback, issue and debug
// signals so the register file and its users connect through one port.
//   slave  : register file side (drives ready, rd_data, rd_busy, dbg_data)
//   master : datapath side (drives addresses, writeback and issue strobes)
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    modport slave (
        output ready, rd_data, rd_busy, dbg_data,
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );

    modport master (
        input  ready, rd_data, rd_busy, dbg_data,
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, dbg_addr
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with optional write-to-read
// bypass, busy-bit scoreboard for multi-cycle producers and a clear sequencer
// that zeroes the array after reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : regfile_sb_if.slave (ready, NRD read ports with busy flags,
//          writeback, issue, raw debug read)
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing reg[cnt], cnt = 1..NREGS-1; outputs forced to 0
// RUN   | ready; writes, issues and reads active
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             clr_we;
    logic             run;
    logic             wr_fire;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;

    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;
    logic [AW-1:0]       ra;

    assign run     = (state_q == RUN);
    assign wr_fire = run && bus.wr_en && (bus.wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Array has no reset: contents are defined by the clear sweep. Entry 0 is
    // never written; reads of address 0 are masked instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                regs[cnt_q] <= '0;
            end else if (wr_fire) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Issue takes priority over writeback so a same-cycle issue/write leaves
    // the register busy for the newer producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (run) begin
            for (int r = 1; r < NREGS; r++) begin
                if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if (bus.wr_en && (bus.wr_addr == AW'(r))) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = bus.rd_addr[i*AW +: AW];
            if (run && (ra != '0)) begin
                if ((BYPASS != 0) && wr_fire && (bus.wr_addr == ra)) begin
                    rd_data_c[i*XLEN +: XLEN] = bus.wr_data;
                    rd_busy_c[i]              = 1'b0;
                end else begin
                    rd_data_c[i*XLEN +: XLEN] = regs[ra];
                    rd_busy_c[i]              = busy_q[ra];
                end
            end
        end
    end

    assign bus.ready    = run;
    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.dbg_data = (run && (bus.dbg_addr != '0)) ? regs[bus.dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stimulus shared by dut_a (BYPASS=1) and dut_b (BYPASS=0)
    logic [9:0]  rd_addr  = '0;
    logic        wr_en    = 1'b0;
    logic [4:0]  wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic        iss_en   = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [4:0]  dbg_addr = '0;

    // Stimulus for dut_c (NRD=3, XLEN=16, NREGS=16)
    logic [11:0] c_rd_addr = '0;
    logic        c_wr_en   = 1'b0;
    logic [3:0]  c_wr_addr = '0;
    logic [15:0] c_wr_data = '0;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifb ();
    regfile_sb_if #(.XLEN(16), .NREGS(16), .NRD(3)) ifc ();

    assign ifa.rd_addr = rd_addr;   assign ifb.rd_addr = rd_addr;
    assign ifa.wr_en = wr_en;       assign ifb.wr_en = wr_en;
    assign ifa.wr_addr = wr_addr;   assign ifb.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data;   assign ifb.wr_data = wr_data;
    assign ifa.iss_en = iss_en;     assign ifb.iss_en = iss_en;
    assign ifa.iss_addr = iss_addr; assign ifb.iss_addr = iss_addr;
    assign ifa.dbg_addr = dbg_addr; assign ifb.dbg_addr = dbg_addr;

    assign ifc.rd_addr  = c_rd_addr;
    assign ifc.wr_en    = c_wr_en;
    assign ifc.wr_addr  = c_wr_addr;
    assign ifc.wr_data  = c_wr_data;
    assign ifc.iss_en   = 1'b0;
    assign ifc.iss_addr = '0;
    assign ifc.dbg_addr = '0;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    regfile_sb #(.XLEN(16), .NREGS(16), .NRD(3), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   ea, ec;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %h with no expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release until dut_a is ready; checks forced-zero
    // outputs while clearing and optionally pulses wr/iss late in the clear.
    task automatic wait_ready(input int pulse_at, output int a_edge, output int c_edge);
        a_edge = 0;
        c_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            wr_en  = 1'b0;
            iss_en = 1'b0;
            if (e == pulse_at) begin
                wr_en    = 1'b1;
                wr_addr  = 5'd5;
                wr_data  = 32'hBAD0BAD0;
                iss_en   = 1'b1;
                iss_addr = 5'd6;
            end
            #1;
            if (ifc.ready === 1'b1 && c_edge == 0) c_edge = e;
            if (ifa.ready === 1'b1) begin
                a_edge = e;
                break;
            end
            push("clr_rd_data", 32'h0);  chk(ifa.rd_data[31:0]);
            push("clr_rd_busy", 32'h0);  chk(32'(ifa.rd_busy));
            push("clr_dbg_data", 32'h0); chk(ifa.dbg_data);
        end
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 edges
        rd_addr  = {5'd7, 5'd3};
        dbg_addr = 5'd7;
        tick();
        push("rst_ready", 32'h0);   chk(32'(ifa.ready));
        push("rst_rd_data", 32'h0); chk(ifa.rd_data[31:0]);
        push("rst_rd_busy", 32'h0); chk(32'(ifa.rd_busy));
        push("rst_dbg", 32'h0);     chk(ifa.dbg_data);
        tick();
        tick();
        rst = 1'b0;
        wait_ready(0, ea, ec);
        push("clear_edges_32", 32'd31); chk(32'(ea));
        push("clear_edges_16", 32'd15); chk(32'(ec));

        for (int r = 0; r < 32; r++) begin
            tick();
            dbg_addr = 5'(r);
            #1;
            push($sformatf("sweep_x%0d", r), 32'h0); chk(ifa.dbg_data);
        end

        // Write x5 / x1 (c), then read back
        tick();
        rd_addr = '0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        c_wr_en = 1'b1; c_wr_addr = 4'd1; c_wr_data = 16'h0011;
        push("x5_a_p0", 32'hDEADBEEF); push("x5_a_p1", 32'hDEADBEEF);
        push("x5_b_p0", 32'hDEADBEEF); push("x5_b_p1", 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd5, 5'd5};
        c_wr_addr = 4'd2; c_wr_data = 16'h0022;
        #1;
        chk(ifa.rd_data[31:0]); chk(ifa.rd_data[63:32]);
        chk(ifb.rd_data[31:0]); chk(ifb.rd_data[63:32]);
        push("c_p0", 32'h0011); push("c_p1", 32'h0022); push("c_p2", 32'h0011);
        tick();
        c_wr_en = 1'b0;
        c_rd_addr = {4'd1, 4'd2, 4'd1};
        #1;
        chk(32'(ifc.rd_data[15:0])); chk(32'(ifc.rd_data[31:16])); chk(32'(ifc.rd_data[47:32]));

        // Write to x0 is ignored, and never bypassed
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h00001234;
        rd_addr = '0; dbg_addr = 5'd0;
        #1;
        push("x0_bypass", 32'h0); chk(ifa.rd_data[31:0]);
        tick();
        wr_en = 1'b0;
        #1;
        push("x0_a", 32'h0);   chk(ifa.rd_data[31:0]);
        push("x0_b", 32'h0);   chk(ifb.rd_data[31:0]);
        push("x0_dbg", 32'h0); chk(ifa.dbg_data);

        // Issue x7 then bypass write to x7
        tick();
        iss_en = 1'b1; iss_addr = 5'd7; rd_addr = {5'd0, 5'd7};
        #1;
        push("iss7_same_cycle", 32'h0); chk(32'(ifa.rd_busy[0]));
        tick();
        iss_en = 1'b0;
        #1;
        push("iss7_busy", 32'h1); chk(32'(ifa.rd_busy[0]));
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; dbg_addr = 5'd7;
        #1;
        push("byp_a_data", 32'hA5A5A5A5); chk(ifa.rd_data[31:0]);
        push("byp_a_busy", 32'h0);        chk(32'(ifa.rd_busy[0]));
        push("nobyp_b_data", 32'h0);      chk(ifb.rd_data[31:0]);
        push("nobyp_b_busy", 32'h1);      chk(32'(ifb.rd_busy[0]));
        push("dbg_no_bypass", 32'h0);     chk(ifa.dbg_data);
        tick();
        wr_en = 1'b0;
        #1;
        push("b_data_next", 32'hA5A5A5A5); chk(ifb.rd_data[31:0]);
        push("b_busy_next", 32'h0);        chk(32'(ifb.rd_busy[0]));
        push("a_busy_next", 32'h0);        chk(32'(ifa.rd_busy[0]));
        push("dbg_next", 32'hA5A5A5A5);    chk(ifa.dbg_data);

        // Scoreboard on x9 via port 1
        rd_addr = {5'd9, 5'd7};
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        push("iss9_same", 32'h0); chk(32'(ifa.rd_busy[1]));
        tick();
        iss_en = 1'b0;
        #1;
        push("iss9_a_busy", 32'h1); chk(32'(ifa.rd_busy[1]));
        push("iss9_b_busy", 32'h1); chk(32'(ifb.rd_busy[1]));
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
        #1;
        push("wr9_a_byp_busy", 32'h0); chk(32'(ifa.rd_busy[1]));
        push("wr9_b_old_busy", 32'h1); chk(32'(ifb.rd_busy[1]));
        tick();
        wr_en = 1'b0;
        #1;
        push("wr9_a_busy", 32'h0);  chk(32'(ifa.rd_busy[1]));
        push("wr9_b_busy", 32'h0);  chk(32'(ifb.rd_busy[1]));
        push("wr9_b_data", 32'h99); chk(ifb.rd_data[63:32]);
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000055;
        #1;
        push("isswr9_a_busy_same", 32'h0); chk(32'(ifa.rd_busy[1]));
        push("isswr9_a_data_same", 32'h55); chk(ifa.rd_data[63:32]);
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        push("isswr9_a_busy", 32'h1); chk(32'(ifa.rd_busy[1]));
        push("isswr9_b_busy", 32'h1); chk(32'(ifb.rd_busy[1]));
        push("isswr9_b_data", 32'h55); chk(ifb.rd_data[63:32]);
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = '0;
        tick();
        iss_en = 1'b0;
        #1;
        push("iss0_p0", 32'h0); chk(32'(ifa.rd_busy[0]));
        push("iss0_p1", 32'h0); chk(32'(ifa.rd_busy[1]));

        // Busy on x3/x4, then reset, and a second reset mid-clear
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd4;
        tick();
        iss_en = 1'b0;
        rd_addr = {5'd4, 5'd3};
        #1;
        push("busy_x3", 32'h1); chk(32'(ifa.rd_busy[0]));
        push("busy_x4", 32'h1); chk(32'(ifa.rd_busy[1]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        push("midrst_ready", 32'h0); chk(32'(ifa.ready));
        rst = 1'b0;
        dbg_addr = 5'd7;
        wait_ready(20, ea, ec);
        push("reclear_edges_32", 32'd31); chk(32'(ea));
        push("reclear_edges_16", 32'd15); chk(32'(ec));
        push("post_busy_x3", 32'h0); chk(32'(ifa.rd_busy[0]));
        push("post_busy_x4", 32'h0); chk(32'(ifa.rd_busy[1]));
        push("post_x7", 32'h0);      chk(ifa.dbg_data);
        rd_addr = {5'd6, 5'd5};
        dbg_addr = 5'd5;
        #1;
        push("clr_wr_x5", 32'h0);   chk(ifa.rd_data[31:0]);
        push("clr_wr_dbg5", 32'h0); chk(ifa.dbg_data);
        push("clr_iss_x6", 32'h0);  chk(32'(ifa.rd_busy[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the RV32I datapath: configurable width, depth and read-port count, optional write-to-read bypass, a busy-bit scoreboard for multi-cycle producers, and a hardware clear sequencer that zeroes the array after reset. It replaces the fixed 2-read/1-write register unit in decode/writeback. It also feeds the hazard logic through per-port busy flags and the debug/display path through a raw debug read port.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of 2, >= 4); register 0 hardwired to zero
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = array contents only
- AW, $clog2(NREGS), derived address width (localparam)

- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- ready  out  1  1 = array cleared and accepting writes/issues
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has a pending producer
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue strobe: mark iss_addr busy
- iss_addr  in  AW  destination of the issued instruction
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data (raw array)

## Operation
- States: CLEAR, RUN. Clear counter cnt is AW bits wide.
- rst=1 at an edge: state<=CLEAR, cnt<=1, all busy bits <=0. Holds there while rst stays high. Applies mid-operation too: any in-flight clear restarts and pending busy bits are dropped.
- CLEAR, rst=0: each cycle writes reg[cnt]<=0 and increments cnt. The cycle that writes reg[NREGS-1] moves to RUN.
- RUN: ready=1. Stays in RUN until rst.
- While ready=0:
  - wr_en and iss_en ignored.
  - rd_data, rd_busy and dbg_data all forced to 0.
- Register 0:
  - Reads always return 0.
  - Writes and issues to address 0 are ignored.
  - busy[0] is constant 0.
- Write, RUN: wr_en with wr_addr!=0 updates reg[wr_addr] at the edge and clears busy[wr_addr].
- Issue, RUN: iss_en with iss_addr!=0 sets busy[iss_addr] at the edge. Issue to an already-busy register leaves it busy.
- Issue and write to the same address in the same cycle: set wins, so busy=1 after the edge and the data is still written.
- Reads, combinational:
  - rd_data[i] = reg[rd_addr[i]], 0 for address 0.
  - rd_busy[i] = busy[rd_addr[i]].
  - Bypass (BYPASS=1, RUN, wr_en, wr_addr==rd_addr[i]!=0): rd_data[i]=wr_data and rd_busy[i]=0.
  - A simultaneous iss_en to that address does not affect same-cycle outputs.
  - BYPASS=0: old value and old busy are shown until the edge.
- Debug port: dbg_data = reg[dbg_addr], 0 for address 0. Never bypassed.
- Duplicate read addresses across ports return identical values.
- Array contents are unknown from power-up until the first CLEAR completes. No initial blocks.

## Timing
- Reset values, outputs (cycle after rst sampled high): ready=0, rd_data=0, rd_busy=0, dbg_data=0.
- Clear duration: ready rises exactly NREGS-1 edges after the first edge with rst=0. That is 31 cycles for NREGS=32.
- Write latency: 1 edge to the array. 0 cycles to the read ports when BYPASS=1.
- Read latency: 0, combinational from rd_addr/dbg_addr.
- Busy set/clear: visible on rd_busy the cycle after the issue/write edge.
- No back-pressure: every wr_en/iss_en presented while ready=1 is accepted.

## Test plan
- Reset/clear, NREGS=32:
  - Assert rst for 3 cycles, then release.
  - ready must stay 0 for 31 edges, then rise.
  - After it rises, all 32 registers read 0 via dbg_addr sweep.
  - rd_* outputs must be 0 throughout the clear.
- Write/read:
  - wr x5=0xDEADBEEF, then read x5 on port 0 and port 1.
  - Next cycle both ports show 0xDEADBEEF.
  - wr x0=0x1234 leaves x0 reading 0.
- Bypass:
  - BYPASS=1: rd_addr0=7 while wr x7=0xA5A5A5A5 → same-cycle rd_data0=0xA5A5A5A5 and rd_busy0=0.
  - BYPASS=0: same stimulus shows the old value that cycle and the new value the next.
  - dbg_addr=7 is never bypassed.
- Scoreboard:
  - iss x9 → rd_busy=1 on x9 next cycle.
  - wr x9 clears it the following cycle.
  - iss x9 and wr x9 in the same cycle → busy=1 and data updated.
  - iss x0 → busy stays 0.
- Reset mid-operation:
  - Set busy on x3 and x4, then assert rst 1 cycle mid-clear of a later reset.
  - Clear restarts from x1 and ready returns 31 cycles after release.
  - Busy bits all 0.
  - wr_en/iss_en pulses during CLEAR have no effect.
- NRD=3, XLEN=16, NREGS=16:
  - Three ports read x1, x2, x1 after writes 0x0011 / 0x0022.
  - Ports show 0x0011, 0x0022, 0x0011.
  - ready rises 15 cycles after reset release.
